traffic_light_monitor: RTL

Passive checker on the receiving end of the Traffic_Light_Controller light buses (light_M1, light_M2, light_MT, light_S). It decodes each 3-bit road signal, tracks each road's phase sequence and the cross-road conflict rules, and reports violations.
- Status outputs are sticky; the error counter saturates.
- It sits beside the controller in the top level and in benches, and never drives the lights.

---
 rtl/tlm_pkg.sv | 29 ++
 rtl/traffic_light_monitor_if.sv | 24 ++
 rtl/tlm_light_tracker.sv | 90 +++++++++
 rtl/traffic_light_monitor.sv | 95 +++++++++
 4 files changed

// File: rtl/tlm_pkg.sv
// Shared constants and types for the traffic light monitor: light encodings,
// tracker states, error flag bit positions and road indices.
package tlm_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [1:0] {
    TRK_INIT   = 2'd0,
    TRK_RED    = 2'd1,
    TRK_GREEN  = 2'd2,
    TRK_YELLOW = 2'd3
  } trk_state_e;

  localparam int ERR_ENC    = 0;
  localparam int ERR_TRANS  = 1;
  localparam int ERR_CONF   = 2;
  localparam int ERR_SGREEN = 3;
  localparam int ERR_SYEL   = 4;
  localparam int ERR_W      = 5;

  localparam int ROAD_M1 = 0;
  localparam int ROAD_M2 = 1;
  localparam int ROAD_MT = 2;
  localparam int ROAD_S  = 3;
  localparam int N_ROADS = 4;

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light buses seen by the monitor plus its clear input and error reporting.
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       light_M1;
  logic [2:0]       light_M2;
  logic [2:0]       light_MT;
  logic [2:0]       light_S;
  logic             clr;
  logic             err_pulse;
  logic [4:0]       err_status;
  logic [3:0]       err_road;
  logic [CNT_W-1:0] err_count;

  modport master (
    output light_M1, light_M2, light_MT, light_S, clr,
    input  err_pulse, err_status, err_road, err_count
  );

  modport slave (
    input  light_M1, light_M2, light_MT, light_S, clr,
    output err_pulse, err_status, err_road, err_count
  );
endinterface

// File: rtl/tlm_light_tracker.sv
// One road: decode, phase FSM, illegal-transition check and, when
// TLM_TIMING_CHECK_EN is defined, the phase duration counter and checks.
module tlm_light_tracker
  import tlm_pkg::*;
#(
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  output logic       non_red,
  output logic       enc_err,
  output logic       trans_err,
  output logic       sgreen_err,
  output logic       syel_err
);

  localparam logic [1:0] ST_INIT   = TRK_INIT;
  localparam logic [1:0] ST_RED    = TRK_RED;
  localparam logic [1:0] ST_GREEN  = TRK_GREEN;
  localparam logic [1:0] ST_YELLOW = TRK_YELLOW;

  function automatic logic [1:0] decode(input logic [2:0] l);
    case (l)
      RED:     decode = ST_RED;
      GREEN:   decode = ST_GREEN;
      YELLOW:  decode = ST_YELLOW;
      default: decode = ST_INIT;
    endcase
  endfunction

  function automatic logic legal(input logic [1:0] from, input logic [1:0] to);
    legal = (from == ST_RED    && to == ST_GREEN)  ||
            (from == ST_GREEN  && to == ST_YELLOW) ||
            (from == ST_YELLOW && to == ST_RED);
  endfunction

  logic       valid;
  logic [1:0] samp;
  logic       changed;
  logic [1:0] state_p1;

  assign valid     = (light == RED) || (light == YELLOW) || (light == GREEN);
  assign samp      = decode(light);
  assign non_red   = (light != RED);
  assign enc_err   = !valid;
  assign changed   = valid && (samp != state_p1);
  assign trans_err = changed && (state_p1 != ST_INIT) && !legal(state_p1, samp);

  // Stage p1: tracked phase; invalid samples leave it untouched
  always_ff @(posedge clk) begin
    if (rst)        state_p1 <= ST_INIT;
    else if (valid) state_p1 <= samp;
  end

`ifdef TLM_TIMING_CHECK_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] dur_p1;
  logic             partial_p1;

  // A phase entered straight from INIT has unknown history, so its length is not judged
  always_ff @(posedge clk) begin
    if (rst) begin
      dur_p1     <= '0;
      partial_p1 <= 1'b0;
    end else if (changed) begin
      dur_p1     <= CNT_W'(1);
      partial_p1 <= (state_p1 == ST_INIT);
    end else if (valid) begin
      dur_p1     <= sat_inc(dur_p1);
    end
  end

  assign sgreen_err = changed && (state_p1 == ST_GREEN) && (samp == ST_YELLOW) &&
                      !partial_p1 && (int'(dur_p1) < MIN_GREEN);
  assign syel_err   = changed && (state_p1 == ST_YELLOW) && (samp == ST_RED) &&
                      !partial_p1 && (int'(dur_p1) < MIN_YELLOW);
`else
  logic unused_cfg;
  assign unused_cfg = ^{MIN_GREEN[0], MIN_YELLOW[0], CNT_W[0]};
  assign sgreen_err = 1'b0;
  assign syel_err   = 1'b0;
`endif

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the four controller light buses: per-road trackers,
// cross-road conflict rules and sticky error reporting (TLM_TIMING_CHECK_EN
// enables the phase duration checks).
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 2,
  parameter int CNT_W      = 8
) (
  input logic                     clk,
  input logic                     rst,
  traffic_light_monitor_if.slave  bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [2:0]         light_arr [N_ROADS];
  logic [N_ROADS-1:0] non_red, enc_r, trans_r, sg_r, sy_r, conf_r;

  assign light_arr[ROAD_M1] = bus.light_M1;
  assign light_arr[ROAD_M2] = bus.light_M2;
  assign light_arr[ROAD_MT] = bus.light_MT;
  assign light_arr[ROAD_S]  = bus.light_S;

  for (genvar g = 0; g < N_ROADS; g++) begin : g_trk
    tlm_light_tracker #(
      .MIN_GREEN (MIN_GREEN),
      .MIN_YELLOW(MIN_YELLOW),
      .CNT_W     (CNT_W)
    ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .light     (light_arr[g]),
      .non_red   (non_red[g]),
      .enc_err   (enc_r[g]),
      .trans_err (trans_r[g]),
      .sgreen_err(sg_r[g]),
      .syel_err  (sy_r[g])
    );
  end

  // S clashes with every other lit road; MT clashes with M2
  logic s_clash, mt_clash;
  assign s_clash  = non_red[ROAD_S] && (non_red[ROAD_M1] || non_red[ROAD_M2] || non_red[ROAD_MT]);
  assign mt_clash = non_red[ROAD_MT] && non_red[ROAD_M2];
  assign conf_r   = ({N_ROADS{s_clash}} & non_red) |
                    (mt_clash ? ((N_ROADS)'(1) << ROAD_MT) | ((N_ROADS)'(1) << ROAD_M2) : '0);

  logic [ERR_W-1:0]   flags;
  logic [N_ROADS-1:0] road_any;
  logic               err_any;
  logic [ERR_W-1:0]   status_base;
  logic [CNT_W-1:0]   count_base;

  assign flags[ERR_ENC]    = |enc_r;
  assign flags[ERR_TRANS]  = |trans_r;
  assign flags[ERR_CONF]   = |conf_r;
  assign flags[ERR_SGREEN] = |sg_r;
  assign flags[ERR_SYEL]   = |sy_r;
  assign road_any          = enc_r | trans_r | conf_r | sg_r | sy_r;
  assign err_any           = |flags;

  logic               err_pulse_p1;
  logic [ERR_W-1:0]   err_status_p1;
  logic [N_ROADS-1:0] err_road_p1;
  logic [CNT_W-1:0]   err_count_p1;

  // Clear takes effect before this cycle's errors are merged in
  assign status_base = bus.clr ? '0 : err_status_p1;
  assign count_base  = bus.clr ? '0 : err_count_p1;

  // Stage p1: registered error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse_p1  <= 1'b0;
      err_status_p1 <= '0;
      err_road_p1   <= '0;
      err_count_p1  <= '0;
    end else begin
      err_pulse_p1  <= err_any;
      err_status_p1 <= status_base | flags;
      err_count_p1  <= err_any ? sat_inc(count_base) : count_base;
      if (err_any) err_road_p1 <= road_any;
    end
  end

  assign bus.err_pulse  = err_pulse_p1;
  assign bus.err_status = err_status_p1;
  assign bus.err_road   = err_road_p1;
  assign bus.err_count  = err_count_p1;

endmodule
